// File: rtl/regwb_buffer.sv
// Register-file writeback merger: pipeline writes win, mdu writes queue in a small FIFO.
// Build option REGWB_STARVE_GUARD_EN adds a stall-based starvation guard for the FIFO head.
module regwb_buffer #(
   parameter int unsigned SIZE         = 31,
   parameter int unsigned ADSIZE       = 4,
   parameter int unsigned DEPTH        = 4,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     pipe_we,
   input  logic [ADSIZE:0]          pipe_addr,
   input  logic [SIZE:0]            pipe_data,
   output logic                     pipe_stall,
   input  logic                     mdu_valid,
   output logic                     mdu_ready,
   input  logic [ADSIZE:0]          mdu_addr,
   input  logic [SIZE:0]            mdu_data,
   input  logic [ADSIZE:0]          pend_a1,
   input  logic [ADSIZE:0]          pend_a2,
   output logic                     pend1,
   output logic                     pend2,
   output logic [$clog2(DEPTH):0]   fifo_count,
   output logic                     WE3,
   output logic [ADSIZE:0]          a3,
   output logic [SIZE:0]            WD3
);

   localparam int unsigned DW = SIZE + 1;
   localparam int unsigned AW = ADSIZE + 1;
   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   logic [AW-1:0] r_mem_addr [DEPTH];
   logic [DW-1:0] r_mem_data [DEPTH];
   logic [PW-1:0] r_wr_ptr;
   logic [PW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;

   logic w_full;
   logic w_empty;
   logic w_push;
   logic w_store;
   logic w_pipe_win;
   logic w_pop;
   logic w_stall;
   logic w_pend1;
   logic w_pend2;

   assign w_full     = (r_count == CW'(DEPTH));
   assign w_empty    = (r_count == '0);
   assign mdu_ready  = !w_full && !rst;
   assign w_push     = mdu_valid && mdu_ready;
   assign w_store    = w_push && (mdu_addr != '0);
   assign w_pipe_win = !rst && pipe_we && (pipe_addr != '0) && !w_stall;
   assign w_pop      = !rst && !w_empty && !w_pipe_win;
   assign fifo_count = r_count;
   assign pipe_stall = w_stall;
   assign pend1      = w_pend1;
   assign pend2      = w_pend2;

`ifdef REGWB_STARVE_GUARD_EN
   localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

   logic [SW-1:0] r_starve;

   // Cycles the head has waited while the pipeline kept winning; saturates at the limit.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_starve <= '0;
      end else if (w_empty || w_pop) begin
         r_starve <= '0;
      end else if (r_starve != SW'(STARVE_LIMIT)) begin
         r_starve <= r_starve + SW'(1);
      end
   end

   assign w_stall = (r_starve == SW'(STARVE_LIMIT));
`else
   logic w_unused_starve_limit;

   assign w_unused_starve_limit = (STARVE_LIMIT == 0);
   assign w_stall               = 1'b0;
`endif

   // FIFO pointers and occupancy; a push and pop in the same cycle leave the count unchanged.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_store) begin
            r_wr_ptr <= r_wr_ptr + PW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PW'(1);
         end
         r_count <= r_count + CW'(w_store) - CW'(w_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (w_store) begin
         r_mem_addr[r_wr_ptr] <= mdu_addr;
         r_mem_data[r_wr_ptr] <= mdu_data;
      end
   end

   // Register-file write port: pipeline first, then FIFO head, else idle with a3/WD3 held.
   always_ff @(posedge clk) begin
      if (rst) begin
         WE3 <= 1'b0;
         a3  <= '0;
         WD3 <= '0;
      end else if (w_pipe_win) begin
         WE3 <= 1'b1;
         a3  <= pipe_addr;
         WD3 <= pipe_data;
      end else if (w_pop) begin
         WE3 <= 1'b1;
         a3  <= r_mem_addr[r_rd_ptr];
         WD3 <= r_mem_data[r_rd_ptr];
      end else begin
         WE3 <= 1'b0;
      end
   end

   // Hazard lookup across the valid window [rd_ptr, rd_ptr + count).
   always_comb begin
      logic [PW-1:0] off;
      w_pend1 = 1'b0;
      w_pend2 = 1'b0;
      off     = '0;
      for (int i = 0; i < DEPTH; i++) begin
         off = PW'(i) - r_rd_ptr;
         if (!rst && (CW'(off) < r_count)) begin
            if ((pend_a1 != '0) && (r_mem_addr[i] == pend_a1)) begin
               w_pend1 = 1'b1;
            end
            if ((pend_a2 != '0) && (r_mem_addr[i] == pend_a2)) begin
               w_pend2 = 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_regwb_buffer.sv
// Directed self-checking bench for regwb_buffer; starvation expectations follow REGWB_STARVE_GUARD_EN.
module tb_regwb_buffer;

   logic        clk;
   logic        rst;
   logic        pipe_we;
   logic [4:0]  pipe_addr;
   logic [31:0] pipe_data;
   logic        pipe_stall;
   logic        mdu_valid;
   logic        mdu_ready;
   logic [4:0]  mdu_addr;
   logic [31:0] mdu_data;
   logic [4:0]  pend_a1;
   logic [4:0]  pend_a2;
   logic        pend1;
   logic        pend2;
   logic [2:0]  fifo_count;
   logic        WE3;
   logic [4:0]  a3;
   logic [31:0] WD3;

   int checks = 0;
   int errors = 0;

   regwb_buffer dut (
      .clk(clk), .rst(rst),
      .pipe_we(pipe_we), .pipe_addr(pipe_addr), .pipe_data(pipe_data), .pipe_stall(pipe_stall),
      .mdu_valid(mdu_valid), .mdu_ready(mdu_ready), .mdu_addr(mdu_addr), .mdu_data(mdu_data),
      .pend_a1(pend_a1), .pend_a2(pend_a2), .pend1(pend1), .pend2(pend2),
      .fifo_count(fifo_count), .WE3(WE3), .a3(a3), .WD3(WD3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

   // Advance one rising edge; outputs are then sampled at the falling edge.
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      checks++; if (WE3 !== 1'b0) begin errors++; $display("FAIL reset_we3: got %b want 0", WE3); end
      checks++; if (a3 !== 5'd0) begin errors++; $display("FAIL reset_a3: got %0d want 0", a3); end
      checks++; if (WD3 !== 32'd0) begin errors++; $display("FAIL reset_wd3: got %h want 0", WD3); end
      checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", fifo_count); end
      checks++; if (pipe_stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", pipe_stall); end
      checks++; if (mdu_ready !== 1'b0) begin errors++; $display("FAIL reset_ready_in_rst: got %b want 0", mdu_ready); end
      rst = 1'b0;
      #1;
      checks++; if (mdu_ready !== 1'b1) begin errors++; $display("FAIL reset_ready_after: got %b want 1", mdu_ready); end
   endtask

   task automatic test_pipe_write();
      pipe_we = 1'b1; pipe_addr = 5'd5; pipe_data = 32'hDEADBEEF;
      tick();
      pipe_we = 1'b0;
      checks++; if (WE3 !== 1'b1) begin errors++; $display("FAIL pipe_we3: got %b want 1", WE3); end
      checks++; if (a3 !== 5'd5) begin errors++; $display("FAIL pipe_a3: got %0d want 5", a3); end
      checks++; if (WD3 !== 32'hDEADBEEF) begin errors++; $display("FAIL pipe_wd3: got %h want deadbeef", WD3); end
      tick();
      checks++; if (WE3 !== 1'b0) begin errors++; $display("FAIL pipe_we3_drop: got %b want 0", WE3); end
      checks++; if (a3 !== 5'd5) begin errors++; $display("FAIL pipe_a3_hold: got %0d want 5", a3); end
   endtask

   task automatic test_fifo_latency();
      mdu_valid = 1'b1; mdu_addr = 5'd10; mdu_data = 32'hA000_000A;
      tick();
      mdu_addr = 5'd11; mdu_data = 32'hB000_000B;
      checks++; if (WE3 !== 1'b0) begin errors++; $display("FAIL lat_no_bypass: got %b want 0", WE3); end
      checks++; if (fifo_count !== 3'd1) begin errors++; $display("FAIL lat_count1: got %0d want 1", fifo_count); end
      tick();
      mdu_valid = 1'b0;
      checks++; if (WE3 !== 1'b1 || a3 !== 5'd10 || WD3 !== 32'hA000_000A) begin
         errors++; $display("FAIL lat_first_pop: got we=%b a3=%0d wd=%h want 1/10/a000000a", WE3, a3, WD3); end
      checks++; if (fifo_count !== 3'd1) begin errors++; $display("FAIL lat_pushpop_count: got %0d want 1", fifo_count); end
      tick();
      checks++; if (WE3 !== 1'b1 || a3 !== 5'd11 || WD3 !== 32'hB000_000B) begin
         errors++; $display("FAIL lat_second_pop: got we=%b a3=%0d wd=%h want 1/11/b000000b", WE3, a3, WD3); end
      checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL lat_empty: got %0d want 0", fifo_count); end
      tick();
      checks++; if (WE3 !== 1'b0) begin errors++; $display("FAIL lat_idle: got %b want 0", WE3); end
   endtask

   task automatic test_fifo_full();
      pipe_we = 1'b1; pipe_addr = 5'd20; pipe_data = 32'h2020_2020;
      mdu_valid = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         mdu_addr = 5'(k); mdu_data = 32'h1000_0000 + 32'(k);
         tick();
      end
      mdu_valid = 1'b0; pipe_we = 1'b0;
      checks++; if (fifo_count !== 3'd4) begin errors++; $display("FAIL full_count: got %0d want 4", fifo_count); end
      checks++; if (mdu_ready !== 1'b0) begin errors++; $display("FAIL full_ready: got %b want 0", mdu_ready); end
      checks++; if (a3 !== 5'd20) begin errors++; $display("FAIL full_pipe_wins: got %0d want 20", a3); end
      for (int k = 1; k <= 4; k++) begin
         tick();
         checks++; if (WE3 !== 1'b1 || a3 !== 5'(k) || WD3 !== 32'h1000_0000 + 32'(k)) begin
            errors++; $display("FAIL full_drain%0d: got we=%b a3=%0d wd=%h want a3=%0d", k, WE3, a3, WD3, k); end
      end
      checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL full_drained: got %0d want 0", fifo_count); end
      tick();
      checks++; if (WE3 !== 1'b0) begin errors++; $display("FAIL full_idle: got %b want 0", WE3); end
   endtask

   task automatic test_zero_addr();
      mdu_valid = 1'b1; mdu_addr = 5'd0; mdu_data = 32'h1234_5678;
      #1;
      checks++; if (mdu_ready !== 1'b1) begin errors++; $display("FAIL zero_handshake: got %b want 1", mdu_ready); end
      tick();
      mdu_valid = 1'b0;
      checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL zero_mdu_count: got %0d want 0", fifo_count); end
      pipe_we = 1'b1; pipe_addr = 5'd0; pipe_data = 32'h8765_4321;
      tick();
      pipe_we = 1'b0;
      checks++; if (WE3 !== 1'b0) begin errors++; $display("FAIL zero_pipe_we3: got %b want 0", WE3); end
      tick();
      checks++; if (WE3 !== 1'b0 || fifo_count !== 3'd0) begin
         errors++; $display("FAIL zero_after: got we=%b count=%0d want 0/0", WE3, fifo_count); end
   endtask

   task automatic test_pending();
      pipe_we = 1'b1; pipe_addr = 5'd21; pipe_data = 32'h2121_2121;
      mdu_valid = 1'b1; mdu_addr = 5'd9; mdu_data = 32'h0909_0909;
      tick();
      mdu_valid = 1'b0; pipe_we = 1'b0;
      pend_a1 = 5'd9; pend_a2 = 5'd0;
      #1;
      checks++; if (pend1 !== 1'b1) begin errors++; $display("FAIL pend1_hit: got %b want 1", pend1); end
      checks++; if (pend2 !== 1'b0) begin errors++; $display("FAIL pend2_zero: got %b want 0", pend2); end
      pend_a2 = 5'd8;
      #1;
      checks++; if (pend2 !== 1'b0) begin errors++; $display("FAIL pend2_miss: got %b want 0", pend2); end
      tick();
      checks++; if (WE3 !== 1'b1 || a3 !== 5'd9) begin errors++; $display("FAIL pend_pop: got we=%b a3=%0d want 1/9", WE3, a3); end
      checks++; if (pend1 !== 1'b0) begin errors++; $display("FAIL pend1_drop: got %b want 0", pend1); end
      pend_a1 = 5'd0; pend_a2 = 5'd0;
   endtask

   task automatic test_starve();
      pipe_we = 1'b1; pipe_addr = 5'd7; pipe_data = 32'h0707_0707;
      mdu_valid = 1'b1; mdu_addr = 5'd12; mdu_data = 32'h0C0C_0C0C;
      tick();
      mdu_valid = 1'b0;
`ifdef REGWB_STARVE_GUARD_EN
      for (int k = 1; k <= 3; k++) begin
         tick();
         checks++; if (pipe_stall !== 1'b0) begin errors++; $display("FAIL starve_early%0d: got %b want 0", k, pipe_stall); end
      end
      tick();
      checks++; if (pipe_stall !== 1'b1) begin errors++; $display("FAIL starve_stall: got %b want 1", pipe_stall); end
      checks++; if (a3 !== 5'd7) begin errors++; $display("FAIL starve_pipe_before: got %0d want 7", a3); end
      tick();
      checks++; if (WE3 !== 1'b1 || a3 !== 5'd12) begin errors++; $display("FAIL starve_head: got we=%b a3=%0d want 1/12", WE3, a3); end
      checks++; if (pipe_stall !== 1'b0) begin errors++; $display("FAIL starve_release: got %b want 0", pipe_stall); end
      tick();
      pipe_we = 1'b0;
      checks++; if (a3 !== 5'd7) begin errors++; $display("FAIL starve_pipe_resume: got %0d want 7", a3); end
`else
      for (int k = 1; k <= 6; k++) begin
         tick();
         checks++; if (pipe_stall !== 1'b0 || a3 !== 5'd7) begin
            errors++; $display("FAIL noguard_cycle%0d: got stall=%b a3=%0d want 0/7", k, pipe_stall, a3); end
      end
      pipe_we = 1'b0;
      tick();
      checks++; if (WE3 !== 1'b1 || a3 !== 5'd12) begin errors++; $display("FAIL noguard_head: got we=%b a3=%0d want 1/12", WE3, a3); end
`endif
      tick();
      checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL starve_empty: got %0d want 0", fifo_count); end
   endtask

   task automatic test_reset_mid();
      pipe_we = 1'b1; pipe_addr = 5'd22; pipe_data = 32'h2222_2222;
      mdu_valid = 1'b1;
      for (int k = 0; k < 3; k++) begin
         mdu_addr = 5'(13 + k); mdu_data = 32'(k);
         tick();
      end
      checks++; if (fifo_count !== 3'd3) begin errors++; $display("FAIL rmid_count3: got %0d want 3", fifo_count); end
      rst = 1'b1; pend_a1 = 5'd13;
      #1;
      checks++; if (mdu_ready !== 1'b0 || pend1 !== 1'b0) begin
         errors++; $display("FAIL rmid_in_rst: got ready=%b pend1=%b want 0/0", mdu_ready, pend1); end
      tick();
      checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL rmid_count0: got %0d want 0", fifo_count); end
      checks++; if (WE3 !== 1'b0 || a3 !== 5'd0) begin errors++; $display("FAIL rmid_we3: got we=%b a3=%0d want 0/0", WE3, a3); end
      rst = 1'b0; mdu_valid = 1'b0; pipe_we = 1'b0; pend_a1 = 5'd0;
      #1;
      checks++; if (mdu_ready !== 1'b1) begin errors++; $display("FAIL rmid_ready: got %b want 1", mdu_ready); end
      tick();
      checks++; if (WE3 !== 1'b0 || fifo_count !== 3'd0) begin
         errors++; $display("FAIL rmid_after: got we=%b count=%0d want 0/0", WE3, fifo_count); end
   endtask

   initial begin
      rst = 1'b1; pipe_we = 1'b0; pipe_addr = '0; pipe_data = '0;
      mdu_valid = 1'b0; mdu_addr = '0; mdu_data = '0; pend_a1 = '0; pend_a2 = '0;
      @(negedge clk);
      test_reset();
      test_pipe_write();
      test_fifo_latency();
      test_fifo_full();
      test_zero_addr();
      test_pending();
      test_starve();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
